// File: rtl/axi_4_lite_regbank.sv
// AXI4-Lite slave register bank for board GPIO (LEDs, switches).
// Ports:
//   AXI_aclk, AXI_aresetn      clock, async active-low reset
//   AXI_aw*/AXI_w*/AXI_b*      write address / data / response channels
//   AXI_ar*/AXI_r*             read address / data channels (arprot ignored)
//   LED                        CTRL register low bits
//   SW                         asynchronous switch inputs
//   IRQ                        level interrupt, |(IRQ_STAT & IRQ_EN), registered
// Register map (word index): 0 CTRL RW, 1 GPIO_IN RO, 2 IRQ_STAT W1C,
// 3 IRQ_EN RW, 4..NUM_REGS-1 scratch RW.
module axi_4_lite_regbank #(
    parameter int unsigned AXI_Dwidth    = 32,
    parameter int unsigned AXI_Addrwidth = 6,
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned GPIO_IN_W     = 4,
    parameter int unsigned GPIO_OUT_W    = 4
) (
    input  logic                       AXI_aclk,
    input  logic                       AXI_aresetn,
    input  logic [AXI_Addrwidth-1:0]   AXI_awaddr,
    input  logic                       AXI_awvalid,
    output logic                       AXI_awready,
    input  logic [AXI_Dwidth-1:0]      AXI_wdata,
    input  logic [AXI_Dwidth/8-1:0]    AXI_wstrb,
    input  logic                       AXI_wvalid,
    output logic                       AXI_wready,
    output logic [1:0]                 AXI_bresp,
    output logic                       AXI_bvalid,
    input  logic                       AXI_bready,
    input  logic [AXI_Addrwidth-1:0]   AXI_araddr,
    input  logic [2:0]                 AXI_arprot,
    input  logic                       AXI_arvalid,
    output logic                       AXI_arready,
    output logic [AXI_Dwidth-1:0]      AXI_rdata,
    output logic [1:0]                 AXI_rresp,
    output logic                       AXI_rvalid,
    input  logic                       AXI_rready,
    output logic [GPIO_OUT_W-1:0]      LED,
    input  logic [GPIO_IN_W-1:0]       SW,
    output logic                       IRQ
);

    localparam int unsigned STRB_W = AXI_Dwidth / 8;
    localparam int unsigned IDX_W  = AXI_Addrwidth - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Write buffers and response
    logic                  aw_full;
    logic [IDX_W-1:0]      aw_idx;
    logic                  w_full;
    logic [AXI_Dwidth-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // Read channel
    logic                  arready_q;
    logic                  rvalid_q;
    logic [AXI_Dwidth-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // Register storage; entries 1 and 2 are never written (served elsewhere)
    logic [AXI_Dwidth-1:0] regs [NUM_REGS];
    logic [GPIO_IN_W-1:0]  irq_stat;
    logic                  irq_q;

    // Switch synchroniser plus edge-detect flop
    logic [GPIO_IN_W-1:0]  sw_meta;
    logic [GPIO_IN_W-1:0]  sw_sync;
    logic [GPIO_IN_W-1:0]  sw_prev;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic                  wr_err;
    logic [AXI_Dwidth-1:0] wr_mask;
    logic [GPIO_IN_W-1:0]  stat_clr;
    logic [GPIO_IN_W-1:0]  sw_rise;
    logic [GPIO_IN_W-1:0]  irq_stat_nxt;
    logic [IDX_W-1:0]      ar_idx;
    logic [AXI_Dwidth-1:0] rd_val;
    logic                  rd_err;
    logic                  rvalid_nxt;
    logic                  unused_ok;

    assign unused_ok = ^{AXI_arprot, AXI_awaddr[1:0], AXI_araddr[1:0]};

    assign aw_hs  = AXI_awvalid & ~aw_full;
    assign w_hs   = AXI_wvalid & ~w_full;
    assign ar_hs  = AXI_arvalid & arready_q;
    assign commit = aw_full & w_full & ~bvalid_q;
    assign ar_idx = AXI_araddr[AXI_Addrwidth-1:2];

    // Write decode: byte mask, error, W1C clear vector
    always_comb begin
        wr_mask  = '0;
        stat_clr = '0;
        wr_err   = (32'(aw_idx) >= NUM_REGS) || (aw_idx == IDX_W'(1));
        for (int unsigned b = 0; b < STRB_W; b++) begin
            wr_mask[8*b +: 8] = {8{w_strb[b]}};
        end
        if (commit && (aw_idx == IDX_W'(2))) begin
            stat_clr = w_data[GPIO_IN_W-1:0] & wr_mask[GPIO_IN_W-1:0];
        end
    end

    // Status update: a rising edge in the same cycle as a clear keeps the bit set
    assign sw_rise      = sw_sync & ~sw_prev;
    assign irq_stat_nxt = (irq_stat & ~stat_clr) | sw_rise;

    // Read decode
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (32'(ar_idx) >= NUM_REGS) begin
            rd_err = 1'b1;
        end else if (ar_idx == IDX_W'(1)) begin
            rd_val = AXI_Dwidth'(sw_sync);
        end else if (ar_idx == IDX_W'(2)) begin
            rd_val = AXI_Dwidth'(irq_stat);
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(ar_idx) == i) begin
                    rd_val = regs[i];
                end
            end
        end
    end

    assign rvalid_nxt = ar_hs | (rvalid_q & ~AXI_rready);

    // Write buffers and B channel
    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= AXI_awaddr[AXI_Addrwidth-1:2];
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full <= 1'b1;
                w_data <= AXI_wdata;
                w_strb <= AXI_wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (AXI_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register file writes
    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && !wr_err) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if ((32'(aw_idx) == i) && (i != 2)) begin
                    regs[i] <= (regs[i] & ~wr_mask) | (w_data & wr_mask);
                end
            end
        end
    end

    // R channel; arready held low during reset, then tracks ~rvalid
    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= ~rvalid_nxt;
            rvalid_q  <= rvalid_nxt;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Switch sync, interrupt status and IRQ
    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            sw_prev  <= '0;
            irq_stat <= '0;
            irq_q    <= 1'b0;
        end else begin
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            sw_prev  <= sw_sync;
            irq_stat <= irq_stat_nxt;
            irq_q    <= |(irq_stat & regs[3][GPIO_IN_W-1:0]);
        end
    end

    assign AXI_awready = ~aw_full;
    assign AXI_wready  = ~w_full;
    assign AXI_bvalid  = bvalid_q;
    assign AXI_bresp   = bresp_q;
    assign AXI_arready = arready_q;
    assign AXI_rvalid  = rvalid_q;
    assign AXI_rdata   = rdata_q;
    assign AXI_rresp   = rresp_q;
    assign LED         = regs[0][GPIO_OUT_W-1:0];
    assign IRQ         = irq_q;

endmodule
